// File: rtl/dcache_assoc_if.sv
// CPU-side and memory-side bus bundle for dcache_assoc.
// slave = the cache, master = the pipeline/memory side.
interface dcache_assoc_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [2:0]        func3;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready;
  logic              hit;
  logic              misalign;
  logic              busy;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr,
    input  cpu_wdata, func3,
    output cpu_rdata, cpu_ready, hit,
    output misalign, busy,
    output mem_req, mem_we, mem_addr,
    output mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr,
    output cpu_wdata, func3,
    input  cpu_rdata, cpu_ready, hit,
    input  misalign, busy,
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/dcache_assoc.sv
// N-way set-associative write-back/write-allocate D-cache, true LRU.
// Define CACHE_STATS_EN to add hit_count/miss_count outputs.
module dcache_assoc #(
  parameter int SETS   = 4,
  parameter int WAYS   = 2,
  parameter int ADDR_W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  dcache_assoc_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int IW = $clog2(SETS);
  localparam int TW = ADDR_W - 2 - IW;
  localparam int AW = $clog2(WAYS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic          valid_q [SETS][WAYS];
  logic          dirty_q [SETS][WAYS];
  logic [TW-1:0] tag_q   [SETS][WAYS];
  logic [31:0]   data_q  [SETS][WAYS];
  logic [AW-1:0] age_q   [SETS][WAYS];

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [AW-1:0]     vic_q, vic_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              hit_q, hit_d;
  logic              mis_q, mis_d;

  logic [IW-1:0] in_idx, rq_idx;
  logic [TW-1:0] in_tag, rq_tag;
  logic [1:0]    in_off;

  assign in_idx = bus.cpu_addr[IW+1:2];
  assign in_tag = bus.cpu_addr[ADDR_W-1:IW+2];
  assign in_off = bus.cpu_addr[1:0];
  assign rq_idx = addr_q[IW+1:2];
  assign rq_tag = addr_q[ADDR_W-1:IW+2];

  function automatic logic illegal(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic bad;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = off[0];
      3'b010:  bad = |off;
      3'b100:  bad = we;
      3'b101:  bad = we | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] load_ext(
    input logic [31:0] w,
    input logic [2:0]  f3,
    input logic [1:0]  off
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] w,
    input logic [31:0] wd,
    input logic [2:0]  f3,
    input logic [1:0]  off
  );
    logic [31:0] r;
    r = w;
    case (f3)
      3'b000:  r[{off, 3'b000} +: 8] = wd[7:0];
      3'b001: begin
        if (off[1]) r[31:16] = wd[15:0];
        else        r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  logic          hit_any;
  logic [AW-1:0] hit_way;
  logic [AW-1:0] vic_way;
  logic          vic_free;
  logic [31:0]   hit_line;

  // Victim: lowest-index invalid way, else the oldest way.
  always_comb begin
    hit_any  = 1'b0;
    hit_way  = '0;
    vic_way  = '0;
    vic_free = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[in_idx][w] &&
          tag_q[in_idx][w] == in_tag) begin
        hit_any = 1'b1;
        hit_way = AW'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[in_idx][w]) begin
        vic_way  = AW'(w);
        vic_free = 1'b1;
      end
    end
    if (!vic_free) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[in_idx][w] == AW'(WAYS - 1))
          vic_way = AW'(w);
      end
    end
    hit_line = data_q[in_idx][hit_way];
  end

  logic          upd, upd_wr, upd_dirty;
  logic [IW-1:0] upd_set;
  logic [AW-1:0] upd_way;
  logic [TW-1:0] upd_tag;
  logic [31:0]   upd_data;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    vic_d     = vic_q;
    rdata_d   = rdata_q;
    hit_d     = hit_q;
    mis_d     = mis_q;
    upd       = 1'b0;
    upd_wr    = 1'b0;
    upd_dirty = 1'b0;
    upd_set   = in_idx;
    upd_way   = hit_way;
    upd_tag   = in_tag;
    upd_data  = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr;
          we_d    = bus.cpu_we;
          wdata_d = bus.cpu_wdata;
          f3_d    = bus.func3;
          hit_d   = 1'b0;
          mis_d   = 1'b0;
          rdata_d = 32'h0;
          if (illegal(bus.cpu_we, bus.func3, in_off)) begin
            mis_d   = 1'b1;
            state_d = S_RESP;
          end else if (hit_any) begin
            hit_d   = 1'b1;
            upd     = 1'b1;
            state_d = S_RESP;
            if (bus.cpu_we) begin
              upd_wr    = 1'b1;
              upd_dirty = 1'b1;
              upd_data  = merge(hit_line, bus.cpu_wdata,
                                bus.func3, in_off);
            end else begin
              rdata_d = load_ext(hit_line, bus.func3, in_off);
            end
          end else begin
            vic_d = vic_way;
            if (valid_q[in_idx][vic_way] &&
                dirty_q[in_idx][vic_way])
              state_d = S_WB;
            else
              state_d = S_FILL;
          end
        end
      end
      S_WB: begin
        if (bus.mem_ready) state_d = S_FILL;
      end
      S_FILL: begin
        if (bus.mem_ready) begin
          upd       = 1'b1;
          upd_wr    = 1'b1;
          upd_set   = rq_idx;
          upd_way   = vic_q;
          upd_tag   = rq_tag;
          upd_dirty = we_q;
          if (we_q) begin
            upd_data = merge(bus.mem_rdata, wdata_q,
                             f3_q, addr_q[1:0]);
          end else begin
            upd_data = bus.mem_rdata;
            rdata_d  = load_ext(bus.mem_rdata, f3_q,
                                addr_q[1:0]);
          end
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      f3_q    <= '0;
      vic_q   <= '0;
      rdata_q <= '0;
      hit_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      vic_q   <= vic_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
      mis_q   <= mis_d;
    end
  end

  // Touched way becomes youngest; younger-than-it ways age by one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          data_q[s][w]  <= '0;
          age_q[s][w]   <= AW'(w);
        end
      end
    end else if (upd) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AW'(w) == upd_way)
          age_q[upd_set][w] <= '0;
        else if (age_q[upd_set][w] <
                 age_q[upd_set][upd_way])
          age_q[upd_set][w] <= age_q[upd_set][w] + 1'b1;
      end
      if (upd_wr) begin
        valid_q[upd_set][upd_way] <= 1'b1;
        dirty_q[upd_set][upd_way] <= upd_dirty;
        tag_q[upd_set][upd_way]   <= upd_tag;
        data_q[upd_set][upd_way]  <= upd_data;
      end
    end
  end

  logic st_wb, st_fill, st_resp;

  assign st_wb   = state_q == S_WB;
  assign st_fill = state_q == S_FILL;
  assign st_resp = state_q == S_RESP;

  assign bus.cpu_ready = st_resp;
  assign bus.busy      = state_q != S_IDLE;
  assign bus.hit       = st_resp & hit_q;
  assign bus.misalign  = st_resp & mis_q;
  assign bus.cpu_rdata = st_resp ? rdata_q : 32'h0;
  assign bus.mem_req   = st_wb | st_fill;
  assign bus.mem_we    = st_wb;

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = 32'h0;
    unique case (1'b1)
      st_wb: begin
        bus.mem_addr  = {tag_q[rq_idx][vic_q], rq_idx, 2'b00};
        bus.mem_wdata = data_q[rq_idx][vic_q];
      end
      st_fill: bus.mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
      default: ;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic        acc_ok;
  logic [31:0] hcnt_q, mcnt_q;

  assign acc_ok = state_q == S_IDLE && bus.cpu_req &&
                  !illegal(bus.cpu_we, bus.func3, in_off);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_q <= '0;
      mcnt_q <= '0;
    end else if (acc_ok) begin
      if (hit_any) hcnt_q <= hcnt_q + 32'd1;
      else         mcnt_q <= mcnt_q + 32'd1;
    end
  end

  assign hit_count  = hcnt_q;
  assign miss_count = mcnt_q;
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc: vector table plus reset/handshake
// sequences against a small word-addressed memory model.
module tb_dcache_assoc;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  always #5 clk = ~clk;

  dcache_assoc_if #(.ADDR_W(32)) bus ();

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dcache_assoc #(
    .SETS(4),
    .WAYS(2),
    .ADDR_W(32)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  logic [31:0] mem [256];
  int          lat = 2;
  int          n_wb = 0;
  int          n_fill = 0;
  logic [31:0] last_wb_addr, last_wb_data, last_fill_addr;

  initial begin
    int          wait_cnt;
    logic [31:0] h_addr, h_wd;
    logic        h_we;
    wait_cnt = 0;
    h_addr = '0;
    h_wd = '0;
    h_we = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
      end else if (bus.mem_req) begin
        if (wait_cnt == 0) begin
          h_addr = bus.mem_addr;
          h_we   = bus.mem_we;
          h_wd   = bus.mem_wdata;
        end else begin
          chk("mem_stable",
              32'(bus.mem_addr == h_addr &&
                  bus.mem_we == h_we &&
                  bus.mem_wdata == h_wd), 32'd1);
        end
        if (wait_cnt >= lat) begin
          wait_cnt = 0;
          bus.mem_ready = 1'b1;
          if (bus.mem_we) begin
            mem[bus.mem_addr[9:2]] = bus.mem_wdata;
            last_wb_addr = bus.mem_addr;
            last_wb_data = bus.mem_wdata;
            n_wb++;
          end else begin
            bus.mem_rdata = mem[bus.mem_addr[9:2]];
            last_fill_addr = bus.mem_addr;
            n_fill++;
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic do_req(input logic we,
                        input logic [31:0] addr,
                        input logic [2:0] f3,
                        input logic [31:0] wd,
                        output logic [31:0] rd,
                        output logic h,
                        output logic m,
                        output logic bsy,
                        output int cyc);
    logic got;
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.func3     = f3;
    bus.cpu_wdata = wd;
    @(posedge clk);
    #1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = ~we;
    bus.cpu_addr  = 32'h3FC;
    bus.func3     = 3'b111;
    bus.cpu_wdata = 32'hFFFF_FFFF;
    cyc = 0;
    got = 1'b0;
    rd = '0;
    h = 1'b0;
    m = 1'b0;
    bsy = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.cpu_ready) begin
        got = 1'b1;
        rd  = bus.cpu_rdata;
        h   = bus.hit;
        m   = bus.misalign;
        bsy = bus.busy;
      end
    end
    chk("ready_timeout", 32'(got), 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        hit;
    logic        mis;
    int          nwb;
    int          nfill;
    logic [31:0] wb_addr;
    logic [31:0] wb_data;
    logic [31:0] fill_addr;
  } vec_t;

  localparam int NV = 24;
  vec_t tv [NV];

  initial begin
    logic [31:0] rd;
    logic        h, m, bsy, got;
    int          cyc, wb0, f0;

    tv[0]  = '{1'b0, 32'h100, 3'b010, 32'h0, 32'hDEADBEEF,
               1'b0, 1'b0, 0, 1, 32'h0, 32'h0, 32'h100};
    tv[1]  = '{1'b0, 32'h100, 3'b010, 32'h0, 32'hDEADBEEF,
               1'b1, 1'b0, 0, 0, 32'h0, 32'h0, 32'h0};
    tv[2]  = '{1'b1, 32'h101, 3'b000, 32'h80, 32'h0,
               1'b1, 1'b0, 0, 0, 32'h0, 32'h0, 32'h0};
    tv[3]  = '{1'b0, 32'h101, 3'b000, 32'h0, 32'hFFFFFF80,
               1'b1, 1'b0, 0, 0, 32'h0, 32'h0, 32'h0};
    tv[4]  = '{1'b0, 32'h101, 3'b100, 32'h0, 32'h00000080,
               1'b1, 1'b0, 0, 0, 32'h0, 32'h0, 32'h0};
    tv[5]  = '{1'b0, 32'h102, 3'b010, 32'h0, 32'h0,
               1'b0, 1'b1, 0, 0, 32'h0, 32'h0, 32'h0};
    tv[6]  = '{1'b0, 32'h102, 3'b001, 32'h0, 32'hFFFFDEAD,
               1'b1, 1'b0, 0, 0, 32'h0, 32'h0, 32'h0};
    tv[7]  = '{1'b0, 32'h100, 3'b101, 32'h0, 32'h000080EF,
               1'b1, 1'b0, 0, 0, 32'h0, 32'h0, 32'h0};
    tv[8]  = '{1'b0, 32'h100, 3'b011, 32'h0, 32'h0,
               1'b0, 1'b1, 0, 0, 32'h0, 32'h0, 32'h0};
    tv[9]  = '{1'b1, 32'h102, 3'b010, 32'hFFFFFFFF, 32'h0,
               1'b0, 1'b1, 0, 0, 32'h0, 32'h0, 32'h0};
    tv[10] = '{1'b1, 32'h000, 3'b010, 32'h11111111, 32'h0,
               1'b0, 1'b0, 0, 1, 32'h0, 32'h0, 32'h000};
    tv[11] = '{1'b1, 32'h010, 3'b010, 32'h22222222, 32'h0,
               1'b0, 1'b0, 1, 1, 32'h100, 32'hDEAD80EF, 32'h010};
    tv[12] = '{1'b0, 32'h020, 3'b010, 32'h0, 32'h12345678,
               1'b0, 1'b0, 1, 1, 32'h000, 32'h11111111, 32'h020};
    tv[13] = '{1'b0, 32'h100, 3'b010, 32'h0, 32'hDEAD80EF,
               1'b0, 1'b0, 1, 1, 32'h010, 32'h22222222, 32'h100};
    tv[14] = '{1'b0, 32'h000, 3'b010, 32'h0, 32'h11111111,
               1'b0, 1'b0, 0, 1, 32'h0, 32'h0, 32'h000};
    tv[15] = '{1'b0, 32'h012, 3'b001, 32'h0, 32'h00002222,
               1'b0, 1'b0, 0, 1, 32'h0, 32'h0, 32'h010};
    tv[16] = '{1'b0, 32'h008, 3'b010, 32'h0, 32'hCAFEF00D,
               1'b0, 1'b0, 0, 1, 32'h0, 32'h0, 32'h008};
    tv[17] = '{1'b0, 32'h018, 3'b010, 32'h0, 32'h0,
               1'b0, 1'b0, 0, 1, 32'h0, 32'h0, 32'h018};
    tv[18] = '{1'b0, 32'h008, 3'b010, 32'h0, 32'hCAFEF00D,
               1'b1, 1'b0, 0, 0, 32'h0, 32'h0, 32'h0};
    tv[19] = '{1'b0, 32'h028, 3'b010, 32'h0, 32'h0,
               1'b0, 1'b0, 0, 1, 32'h0, 32'h0, 32'h028};
    tv[20] = '{1'b0, 32'h008, 3'b010, 32'h0, 32'hCAFEF00D,
               1'b1, 1'b0, 0, 0, 32'h0, 32'h0, 32'h0};
    tv[21] = '{1'b1, 32'h006, 3'b001, 32'h0000ABCD, 32'h0,
               1'b0, 1'b0, 0, 1, 32'h0, 32'h0, 32'h004};
    tv[22] = '{1'b0, 32'h006, 3'b001, 32'h0, 32'hFFFFABCD,
               1'b1, 1'b0, 0, 0, 32'h0, 32'h0, 32'h0};
    tv[23] = '{1'b0, 32'h004, 3'b010, 32'h0, 32'hABCD0000,
               1'b1, 1'b0, 0, 0, 32'h0, 32'h0, 32'h0};

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'hDEADBEEF;
    mem[8'h08] = 32'h12345678;
    mem[8'h02] = 32'hCAFEF00D;

    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'h0;
    bus.cpu_wdata = 32'h0;
    bus.func3     = 3'b010;

    #1 reset_n = 1'b0;
    #2;
    chk("rst cpu_rdata", bus.cpu_rdata, 32'h0);
    chk("rst cpu_ready", 32'(bus.cpu_ready), 32'h0);
    chk("rst hit", 32'(bus.hit), 32'h0);
    chk("rst misalign", 32'(bus.misalign), 32'h0);
    chk("rst busy", 32'(bus.busy), 32'h0);
    chk("rst mem_req", 32'(bus.mem_req), 32'h0);
    chk("rst mem_we", 32'(bus.mem_we), 32'h0);
    chk("rst mem_addr", bus.mem_addr, 32'h0);
    chk("rst mem_wdata", bus.mem_wdata, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      wb0 = n_wb;
      f0  = n_fill;
      do_req(tv[i].we, tv[i].addr, tv[i].f3, tv[i].wd,
             rd, h, m, bsy, cyc);
      chk($sformatf("v%0d rdata", i), rd, tv[i].rd);
      chk($sformatf("v%0d hit", i), 32'(h), 32'(tv[i].hit));
      chk($sformatf("v%0d misalign", i), 32'(m), 32'(tv[i].mis));
      chk($sformatf("v%0d busy", i), 32'(bsy), 32'd1);
      chk($sformatf("v%0d n_wb", i), 32'(n_wb - wb0),
          32'(tv[i].nwb));
      chk($sformatf("v%0d n_fill", i), 32'(n_fill - f0),
          32'(tv[i].nfill));
      if (tv[i].hit || tv[i].mis)
        chk($sformatf("v%0d latency", i), 32'(cyc), 32'd1);
      if (tv[i].nwb > 0) begin
        chk($sformatf("v%0d wb_addr", i), last_wb_addr,
            tv[i].wb_addr);
        chk($sformatf("v%0d wb_data", i), last_wb_data,
            tv[i].wb_data);
      end
      if (tv[i].nfill > 0)
        chk($sformatf("v%0d fill_addr", i), last_fill_addr,
            tv[i].fill_addr);
    end

    // Reset while a fill is outstanding; dirty 0x004 is dropped.
    lat = 20;
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h044;
    bus.func3    = 3'b010;
    @(posedge clk);
    #1 bus.cpu_req = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      got = bus.mem_req;
    end
    chk("midfill mem_req", 32'(got), 32'd1);
    chk("midfill mem_addr", bus.mem_addr, 32'h044);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midfill rst mem_req", 32'(bus.mem_req), 32'd0);
    chk("midfill rst busy", 32'(bus.busy), 32'd0);
    chk("midfill rst mem_addr", bus.mem_addr, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    lat = 2;
    wb0 = n_wb;
    f0  = n_fill;
    do_req(1'b0, 32'h004, 3'b010, 32'h0, rd, h, m, bsy, cyc);
    chk("post-rst hit", 32'(h), 32'd0);
    chk("post-rst rdata", rd, 32'h0);
    chk("post-rst n_wb", 32'(n_wb - wb0), 32'd0);
    chk("post-rst n_fill", 32'(n_fill - f0), 32'd1);

    // A request held through the response cycle is not accepted.
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h004;
    bus.func3    = 3'b010;
    @(posedge clk);
    #1 bus.cpu_addr = 32'h044;
    @(negedge clk);
    chk("resp ready", 32'(bus.cpu_ready), 32'd1);
    chk("resp hit", 32'(bus.hit), 32'd1);
    chk("resp rdata", bus.cpu_rdata, 32'h0);
    @(posedge clk);
    #1 bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("resp-req ignored busy", 32'(bus.busy), 32'd0);
    chk("resp-req ignored mem_req", 32'(bus.mem_req), 32'd0);

`ifdef CACHE_STATS_EN
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("stats rst hit_count", hit_count, 32'd0);
    chk("stats rst miss_count", miss_count, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    do_req(1'b0, 32'h200, 3'b010, 32'h0, rd, h, m, bsy, cyc);
    do_req(1'b0, 32'h200, 3'b010, 32'h0, rd, h, m, bsy, cyc);
    do_req(1'b0, 32'h200, 3'b010, 32'h0, rd, h, m, bsy, cyc);
    do_req(1'b0, 32'h102, 3'b010, 32'h0, rd, h, m, bsy, cyc);
    chk("stats misalign", 32'(m), 32'd1);
    do_req(1'b0, 32'h300, 3'b010, 32'h0, rd, h, m, bsy, cyc);
    do_req(1'b0, 32'h300, 3'b010, 32'h0, rd, h, m, bsy, cyc);
    chk("stats hit_count", hit_count, 32'd3);
    chk("stats miss_count", miss_count, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dcache_assoc.md
# dcache_assoc

Parametrised N-way set-associative, write-back, write-allocate data cache sitting between the pipeline MEM stage and data memory. It replaces the fixed 2-way write-through cache. Sets, ways and address width are parameters, replacement is true LRU, and dirty lines are written back on eviction. RISC-V sub-word loads and stores are resolved inside the cache, and a valid/ready port connects it to external memory instead of an embedded memory instance.

## Interface
- SETS, 4, number of sets; power of two, ≥2
- WAYS, 2, associativity; power of two, ≥2
- ADDR_W, 32, byte address width; tag width = ADDR_W − 2 − log2(SETS)
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- cpu_req  in  1  request strobe, sampled only while busy=0
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  32  store data, right-aligned
- func3  in  3  RISC-V width code: LB/LH/LW/LBU/LHU, SB/SH/SW
- cpu_rdata  out  32  load result, sign- or zero-extended per func3
- cpu_ready  out  1  one-cycle completion pulse
- hit  out  1  valid with cpu_ready; 1 = request hit
- misalign  out  1  valid with cpu_ready; 1 = misaligned or illegal func3
- busy  out  1  1 = request in flight; new cpu_req is ignored
- mem_req / mem_we  out  1 / 1  memory request and write select
- mem_addr  out  ADDR_W  word address, bits [1:0] = 0
- mem_wdata  out  32  write-back data
- mem_rdata  in  32  fill data, valid when mem_ready=1 and mem_we=0
- mem_ready  in  1  memory completion; ignored while mem_req=0
- hit_count, miss_count  out  32 each  present only with CACHE_STATS_EN

## Operation
- Each line holds one 32-bit word with valid, dirty, tag and LRU age. Index = addr[log2(SETS)+1:2]. Tag = addr[ADDR_W−1:log2(SETS)+2].
- On acceptance (IDLE, cpu_req=1), the cache latches addr, we, wdata and func3. Later input changes are ignored.
- Misaligned access: LW/SW with addr[1:0]≠0, or LH/LHU/SH with addr[0]≠0. An undefined func3 is treated the same way. The cache makes no array or memory access and leaves the counters unchanged. The response is misalign=1, hit=0, cpu_rdata=0.
- States:
  - IDLE→RESP on a hit or misaligned access.
  - IDLE→WB on a miss whose victim is valid and dirty.
  - IDLE→FILL on a miss with a clean or invalid victim.
  - WB→FILL on mem_ready.
  - FILL→RESP on mem_ready.
  - RESP→IDLE always.
- Victim selection: the lowest-index invalid way; otherwise the way with the highest age.
- LRU ages form a permutation of 0..WAYS−1 per set. Reset sets way w to age w.
- On a hit or install to way k, age[k] becomes 0 and every way whose age was below k's old age increments by 1.
- WB: mem_we=1, mem_addr = {victim tag, index, 2'b00}, mem_wdata = victim data.
- FILL: mem_we=0, mem_addr = {req tag, index, 2'b00}. On mem_ready the line is installed with valid=1 and dirty=0. A store then merges into the line.
- Stores merge SB/SH/SW bytes into the line and set dirty=1. A store never writes memory directly.
- Loads extract the byte/half selected by addr[1:0] and sign-extend (LB/LH) or zero-extend (LBU/LHU).

## Timing
- Reset (reset_n=0, asynchronous): all valid and dirty bits clear, ages reset to their initial values, counters 0, state IDLE. All outputs are 0: cpu_rdata, cpu_ready, hit, misalign, busy, mem_req, mem_we, mem_addr, mem_wdata.
- Reset during WB/FILL drops mem_req immediately and discards dirty data.
- Hit latency: accepted at edge N, cpu_ready=1 in cycle N+1 with hit=1; busy=1 only during cycle N+1.
- Miss latency: busy rises the cycle after acceptance. mem_req rises in the same cycle, and mem_addr, mem_we and mem_wdata stay stable until mem_ready is sampled.
  - After a WB mem_ready, mem_req stays high with the FILL address on the next cycle (one cycle gap allowed).
  - After the FILL mem_ready, cpu_ready=1 and hit=0 on the next cycle, with the final cpu_rdata.
- busy falls in the cycle after cpu_ready. cpu_req sampled in the cpu_ready cycle is ignored.

## Configuration
- CACHE_STATS_EN defined: hit_count and miss_count ports exist. Each hit or miss acceptance increments the corresponding 32-bit counter, which wraps at 2^32. Misaligned requests are not counted.
- CACHE_STATS_EN undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Cold LW 0x100, memory returns 0xDEADBEEF after 3 cycles → FILL only (no WB); cpu_rdata=0xDEADBEEF, hit=0. Repeat LW 0x100 → hit=1 one cycle after acceptance, no mem_req.
- SB 0x101 ← 0x80 after the line is filled → no mem_req. LB 0x101 → 0xFFFFFF80. LBU 0x101 → 0x00000080.
- With SETS=4, WAYS=2, store to 0x000 then 0x010, then LW 0x020 → way 0 (LRU) evicted. WB to 0x000 with the stored data, then FILL 0x020.
- LW 0x102 → misalign=1, cpu_rdata=0, no mem_req, counters unchanged. LH 0x102 → a legal access.
- Assert reset_n=0 mid-FILL → mem_req=0 immediately. LW of the previously cached address misses afterwards.
- CACHE_STATS_EN build, sequence of 3 hits and 2 misses → hit_count=3, miss_count=2.
